// File: rtl/decode_pkg.sv
// Shared MIPS-I decode types: operation enum, opcode/funct/REGIMM constants,
// decoded-entry structs and the memory-op classifier.
package decode_pkg;

  typedef enum logic [5:0] {
    OP_SLL = 6'd0, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR,
    OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
    OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
    OP_SB, OP_SH, OP_SW,
    OP_ILLEGAL = 6'd63
  } op_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03, OPC_BEQ    = 6'h04, OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_BLEZ    = 6'h06, OPC_BGTZ   = 6'h07, OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU   = 6'h09, OPC_SLTI   = 6'h0A, OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI    = 6'h0C, OPC_ORI    = 6'h0D, OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F, OPC_LB     = 6'h20, OPC_LH    = 6'h21;
  localparam logic [5:0] OPC_LWL     = 6'h22, OPC_LW     = 6'h23, OPC_LBU   = 6'h24;
  localparam logic [5:0] OPC_LHU     = 6'h25, OPC_LWR    = 6'h26, OPC_SB    = 6'h28;
  localparam logic [5:0] OPC_SH      = 6'h29, OPC_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU= 6'h19, FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B, FN_ADD   = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, RT_BLTZAL = 5'd16, RT_BGEZAL = 5'd17;

  typedef struct packed {
    op_t         op;
    logic        illegal;
    logic        is_mem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] addr;
  } dec_t;

  typedef struct packed {
    dec_t        dec;
    logic [31:0] pc;
  } entry_t;

  function automatic logic is_mem_op(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
      default:             is_mem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_decode_comb.sv
// Combinational MIPS-I decoder: instruction word to operation, legality,
// memory-op flag and raw fields.
module mips_decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  op_t        op;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];

  always_comb begin
    op = OP_ILLEGAL;
    case (opcode)
      OPC_SPECIAL: begin
        case (funct)
          FN_SLL:   op = OP_SLL;
          FN_SRL:   op = OP_SRL;
          FN_SRA:   op = OP_SRA;
          FN_SLLV:  op = OP_SLLV;
          FN_SRLV:  op = OP_SRLV;
          FN_SRAV:  op = OP_SRAV;
          FN_JR:    op = OP_JR;
          FN_MFHI:  op = OP_MFHI;
          FN_MFLO:  op = OP_MFLO;
          FN_MULT:  op = OP_MULT;
          FN_MULTU: op = OP_MULTU;
          FN_DIV:   op = OP_DIV;
          FN_DIVU:  op = OP_DIVU;
          FN_ADD:   op = OP_ADD;
          FN_ADDU:  op = OP_ADDU;
          FN_SUB:   op = OP_SUB;
          FN_SUBU:  op = OP_SUBU;
          FN_AND:   op = OP_AND;
          FN_OR:    op = OP_OR;
          FN_XOR:   op = OP_XOR;
          FN_NOR:   op = OP_NOR;
          FN_SLT:   op = OP_SLT;
          FN_SLTU:  op = OP_SLTU;
          default:  op = OP_ILLEGAL;
        endcase
      end
      OPC_REGIMM: begin
        case (rt)
          RT_BLTZ:   op = OP_BLTZ;
          RT_BGEZ:   op = OP_BGEZ;
          RT_BLTZAL: op = OP_BLTZAL;
          RT_BGEZAL: op = OP_BGEZAL;
          default:   op = OP_ILLEGAL;
        endcase
      end
      OPC_J:     op = OP_J;
      OPC_JAL:   op = OP_JAL;
      OPC_BEQ:   op = OP_BEQ;
      OPC_BNE:   op = OP_BNE;
      // The compare-with-zero branches encode a second register slot that must be empty.
      OPC_BLEZ:  op = (rt == 5'd0) ? OP_BLEZ : OP_ILLEGAL;
      OPC_BGTZ:  op = (rt == 5'd0) ? OP_BGTZ : OP_ILLEGAL;
      OPC_ADDI:  op = OP_ADDI;
      OPC_ADDIU: op = OP_ADDIU;
      OPC_SLTI:  op = OP_SLTI;
      OPC_SLTIU: op = OP_SLTIU;
      OPC_ANDI:  op = OP_ANDI;
      OPC_ORI:   op = OP_ORI;
      OPC_XORI:  op = OP_XORI;
      OPC_LUI:   op = OP_LUI;
      OPC_LB:    op = OP_LB;
      OPC_LH:    op = OP_LH;
      OPC_LWL:   op = OP_LWL;
      OPC_LW:    op = OP_LW;
      OPC_LBU:   op = OP_LBU;
      OPC_LHU:   op = OP_LHU;
      OPC_LWR:   op = OP_LWR;
      OPC_SB:    op = OP_SB;
      OPC_SH:    op = OP_SH;
      OPC_SW:    op = OP_SW;
      default:   op = OP_ILLEGAL;
    endcase
  end

  assign dec.op      = op;
  assign dec.illegal = (op == OP_ILLEGAL);
  assign dec.is_mem  = is_mem_op(op);
  assign dec.rs      = instr[25:21];
  assign dec.rt      = instr[20:16];
  assign dec.rd      = instr[15:11];
  assign dec.shamt   = instr[10:6];
  assign dec.imm     = instr[15:0];
  assign dec.addr    = instr[25:0];

endmodule

// File: rtl/decode_queue.sv
// Registered decode stage: instructions are decoded on entry and held in a
// circular queue; the head is presented to execute and stalled on busy memory.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  input  logic              waitrequest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stall,
  output op_t               out_op,
  output logic              out_illegal,
  output logic              out_is_mem,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [15:0]       out_imm,
  output logic [25:0]       out_addr,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

  entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  dec_t                in_dec;
  entry_t              head;
  logic                enq, deq;

  mips_decode_comb u_dec (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign head      = mem_q[rd_ptr_q];
  // Ready looks only at registered count so there is no in_ready <- out_ready path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign stall     = out_valid && head.dec.is_mem && waitrequest;

  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !stall && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq) begin
      mem_q[wr_ptr_q] <= '{dec: in_dec, pc: in_pc};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign out_op       = head.dec.op;
  assign out_illegal  = head.dec.illegal;
  assign out_is_mem   = head.dec.is_mem;
  assign out_rs       = head.dec.rs;
  assign out_rt       = head.dec.rt;
  assign out_rd       = head.dec.rd;
  assign out_shamt    = head.dec.shamt;
  assign out_imm      = head.dec.imm;
  assign out_addr     = head.dec.addr;
  assign out_pc       = head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, 2-bit stall counter to reach saturation).
module tb_decode_queue;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, waitrequest, out_valid, out_ready, stall;
  logic [31:0] in_instr, in_pc, out_pc;
  op_t         out_op;
  logic        out_illegal, out_is_mem;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_addr;
  logic [1:0]  stall_cycles;

  int vecs = 0;
  int miscmp = 0;

  decode_queue #(.DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .waitrequest(waitrequest),
    .out_valid(out_valid), .out_ready(out_ready), .stall(stall), .out_op(out_op),
    .out_illegal(out_illegal), .out_is_mem(out_is_mem), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm), .out_addr(out_addr),
    .out_pc(out_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; waitrequest = 0; out_ready = 0;
    #2;
    vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin miscmp++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++; if (out_op !== OP_SLL) begin miscmp++; $display("FAIL reset_out_op got %0d want %0d", out_op, OP_SLL); end
    vecs++; if (out_pc !== 32'h0) begin miscmp++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    vecs++; if (stall_cycles !== 2'd0) begin miscmp++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
    @(negedge clk); reset_n = 1'b1;
    step();
  endtask

  task automatic test_simple_decode();
    push(32'h24220005, 32'hBFC00000);
    vecs++; if (out_valid !== 1'b1) begin miscmp++; $display("FAIL simple_out_valid got %b want 1", out_valid); end
    vecs++; if (out_op !== OP_ADDIU) begin miscmp++; $display("FAIL simple_op got %0d want %0d", out_op, OP_ADDIU); end
    vecs++; if (out_rs !== 5'd1 || out_rt !== 5'd2) begin miscmp++; $display("FAIL simple_rs_rt got %0d/%0d want 1/2", out_rs, out_rt); end
    vecs++; if (out_imm !== 16'h0005) begin miscmp++; $display("FAIL simple_imm got %h want 0005", out_imm); end
    vecs++; if (out_pc !== 32'hBFC00000) begin miscmp++; $display("FAIL simple_pc got %h want bfc00000", out_pc); end
    vecs++; if (out_is_mem !== 1'b0 || out_illegal !== 1'b0) begin miscmp++; $display("FAIL simple_flags got mem=%b ill=%b want 0/0", out_is_mem, out_illegal); end
    // Memory busy must not hold a non-memory head.
    waitrequest = 1'b1; out_ready = 1'b1; #1;
    vecs++; if (stall !== 1'b0) begin miscmp++; $display("FAIL nonmem_stall got %b want 0", stall); end
    step();
    vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL nonmem_dequeue got out_valid=%b want 0", out_valid); end
    waitrequest = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_mem_stall();
    push(32'h8C430004, 32'h00000100);
    vecs++; if (out_op !== OP_LW || out_is_mem !== 1'b1) begin miscmp++; $display("FAIL lw_decode got op=%0d mem=%b want %0d/1", out_op, out_is_mem, OP_LW); end
    waitrequest = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (stall !== 1'b1) begin miscmp++; $display("FAIL stall_cycle%0d got %b want 1", i, stall); end
      vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin miscmp++; $display("FAIL stall_hold%0d got v=%b pc=%h want 1/100", i, out_valid, out_pc); end
      step();
    end
    waitrequest = 1'b0; #1;
    vecs++; if (stall !== 1'b0) begin miscmp++; $display("FAIL stall_release got %b want 0", stall); end
    step();
    vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL stall_dequeue got out_valid=%b want 0", out_valid); end
    vecs++; if (stall_cycles !== 2'd3) begin miscmp++; $display("FAIL stall_count got %0d want 3", stall_cycles); end
    // One more stalled cycle: the 2-bit counter is already all-ones and must hold.
    out_ready = 1'b0;
    push(32'hAC430008, 32'h00000104);
    waitrequest = 1'b1; out_ready = 1'b1;
    step();
    waitrequest = 1'b0;
    step();
    vecs++; if (stall_cycles !== 2'd3) begin miscmp++; $display("FAIL stall_saturate got %0d want 3", stall_cycles); end
    vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL sw_dequeue got out_valid=%b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_queue();
    push(32'h24010001, 32'h200);
    vecs++; if (in_ready !== 1'b1) begin miscmp++; $display("FAIL full_after1 got in_ready=%b want 1", in_ready); end
    push(32'h24020002, 32'h204);
    vecs++; if (in_ready !== 1'b0) begin miscmp++; $display("FAIL full_after2 got in_ready=%b want 0", in_ready); end
    in_valid = 1'b1; in_instr = 32'h24030003; in_pc = 32'h208;
    step();
    vecs++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin miscmp++; $display("FAIL full_hold got rdy=%b pc=%h want 0/200", in_ready, out_pc); end
    out_ready = 1'b1;
    step();
    vecs++; if (in_ready !== 1'b1 || out_pc !== 32'h204 || out_imm !== 16'h2) begin miscmp++; $display("FAIL full_drain1 got rdy=%b pc=%h imm=%h want 1/204/0002", in_ready, out_pc, out_imm); end
    step();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_imm !== 16'h3) begin miscmp++; $display("FAIL full_drain2 got v=%b pc=%h imm=%h want 1/208/0003", out_valid, out_pc, out_imm); end
    step();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscmp++; $display("FAIL full_empty got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    push(32'h24040004, 32'h300);
    push(32'h24050005, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h24060006; in_pc = 32'h308;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscmp++; $display("FAIL flush_empty got v=%b rdy=%b want 0/1", out_valid, in_ready); end
    step();
    vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL flush_no_enq got out_valid=%b want 0", out_valid); end
    push(32'h24070007, 32'h30C);
    vecs++; if (out_valid !== 1'b1 || out_pc !== 32'h30C) begin miscmp++; $display("FAIL flush_restart got v=%b pc=%h want 1/30c", out_valid, out_pc); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] instrs [4];
    op_t         ops [4];
    logic        ills [4];
    instrs = '{32'hFC000000, 32'h04050000, 32'h1C010000, 32'h3C011234};
    ops    = '{OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_LUI};
    ills   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      push(instrs[i], 32'h400 + 32'(i * 4));
      vecs++; if (out_op !== ops[i] || out_illegal !== ills[i] || out_is_mem !== 1'b0)
        begin miscmp++; $display("FAIL illegal%0d got op=%0d ill=%b mem=%b want %0d/%b/0", i, out_op, out_illegal, out_is_mem, ops[i], ills[i]); end
      out_ready = 1'b1; step(); out_ready = 1'b0;
      vecs++; if (out_valid !== 1'b0) begin miscmp++; $display("FAIL illegal_deq%0d got out_valid=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    push(32'h8C430004, 32'h500);
    push(32'h24080008, 32'h504);
    waitrequest = 1'b1; #1;
    vecs++; if (stall !== 1'b1) begin miscmp++; $display("FAIL rmid_stall got %b want 1", stall); end
    #1; reset_n = 1'b0; #1;
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall !== 1'b0) begin miscmp++; $display("FAIL rmid_async got v=%b rdy=%b st=%b want 0/1/0", out_valid, in_ready, stall); end
    vecs++; if (out_op !== OP_SLL || out_pc !== 32'h0 || out_is_mem !== 1'b0) begin miscmp++; $display("FAIL rmid_fields got op=%0d pc=%h mem=%b want 0/0/0", out_op, out_pc, out_is_mem); end
    vecs++; if (stall_cycles !== 2'd0) begin miscmp++; $display("FAIL rmid_cnt got %0d want 0", stall_cycles); end
    @(negedge clk); reset_n = 1'b1; waitrequest = 1'b0;
    step();
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall_cycles !== 2'd0) begin miscmp++; $display("FAIL rmid_release got rdy=%b v=%b cnt=%0d want 1/0/0", in_ready, out_valid, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_simple_decode();
    test_mem_stall();
    test_full_queue();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
